// File: rtl/rf_pkg.sv
// Shared types and defaults for the multi-port register file.
package rf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCRUB = 2'd1,
    DONE  = 2'd2
  } scrub_state_t;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_NREAD  = 2;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/rf_scrub_fsm.sv
// Scrub sequencer: walks every entry once, issuing a zero-write per cycle.
module rf_scrub_fsm
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              scrub_req,
  output logic              scrub_busy,
  output logic              scrub_done,
  output logic              wr_ready,
  output logic              scrub_we,
  output logic [ADDR_W-1:0] scrub_addr
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  scrub_state_t      state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    scrub_we   = 1'b0;
    scrub_addr = cnt;
    scrub_busy = 1'b0;
    scrub_done = 1'b0;
    wr_ready   = 1'b0;
    unique case (state)
      IDLE: begin
        wr_ready = 1'b1;
        if (scrub_req) begin
          state_nxt = SCRUB;
          cnt_nxt   = '0;
        end
      end
      SCRUB: begin
        scrub_busy = 1'b1;
        scrub_we   = 1'b1;
        // Exit on the last index so cnt never wraps.
        if (cnt == ADDR_W'(DEPTH - 1)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        scrub_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional zero register and soft scrub.
// Optional write-through forwarding is enabled by defining RF_BYPASS_EN.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned NREAD   = DEF_NREAD,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  output logic                    wr_ready,
  input  logic                    scrub_req,
  output logic                    scrub_busy,
  output logic                    scrub_done
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              scrub_we;
  logic [ADDR_W-1:0] scrub_addr;
  logic              wr_accept;
  logic              wr_drop;

  rf_scrub_fsm #(
    .ADDR_W(ADDR_W)
  ) u_scrub (
    .clk       (clk),
    .clr       (clr),
    .scrub_req (scrub_req),
    .scrub_busy(scrub_busy),
    .scrub_done(scrub_done),
    .wr_ready  (wr_ready),
    .scrub_we  (scrub_we),
    .scrub_addr(scrub_addr)
  );

  assign wr_accept = wr_en && wr_ready;
  assign wr_drop   = (ZERO_R0 != 0) && (wr_addr == '0);

  // Scrub and external writes are mutually exclusive: wr_ready is low while scrubbing.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (scrub_we) begin
      mem[scrub_addr] <= '0;
    end else if (wr_accept && !wr_drop) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rv = mem[ra];
`ifdef RF_BYPASS_EN
      if (wr_accept && (wr_addr == ra)) rv = wr_data;
`endif
      if ((ZERO_R0 != 0) && (ra == '0)) rv = '0;
    end

    assign rd_data[k*DATA_W +: DATA_W] = rv;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the RISC datapath, the successor of the fixed 16x16 two-port file. Provides synchronous edge-triggered writes, combinational reads on NREAD ports, an optional hardwired-zero register 0, and a sequential scrub engine that zeroes the array one entry per cycle without asserting reset. It sits between decode (read addresses) and writeback (write port).

## Interface

- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries
- NREAD, 2, number of independent read ports
- ZERO_R0, 1, when 1 entry 0 always reads 0 and writes to it are dropped

- clk  in  1  rising-edge clock
- clr  in  1  reset, asynchronous and active-high; one clock, no other reset
- rd_addr  in  NREAD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NREAD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ready  out  1  high when a write request is accepted this cycle
- scrub_req  in  1  start a soft clear of all entries
- scrub_busy  out  1  high while scrub is in progress
- scrub_done  out  1  one-cycle pulse after the last entry is cleared

## Operation

- Array: DEPTH x DATA_W flops. Reads are combinational from rd_addr.
- Write: on a rising clk edge with wr_en && wr_ready, entry[wr_addr] <= wr_data. If ZERO_R0 is set and wr_addr==0, the write is dropped.
- Reads: rd_data[k] = entry[rd_addr[k]]. If ZERO_R0 is set and rd_addr[k]==0, the result is 0 regardless of bypass.
- Scrub FSM states:
  - IDLE: if scrub_req is high, go to SCRUB with cnt=0.
  - SCRUB: each cycle entry[cnt] <= 0 and cnt++. When cnt==DEPTH-1 is cleared, go to DONE.
  - DONE: scrub_done=1 for one cycle, then go to IDLE.
- wr_ready = (state==IDLE). Writes requested in SCRUB or DONE are ignored, not queued. The producer must hold the request until wr_ready is high.
- scrub_req is ignored outside IDLE. A held scrub_req restarts a scrub on the cycle after DONE.
- Simultaneous scrub_req and wr_en in IDLE: the write is accepted (wr_ready is still 1 that cycle), and the scrub begins on the next cycle.
- Reads during scrub return current contents: entries already cleared read 0, entries not yet cleared read their old values.

## Timing

- Reset values: all entries 0, state IDLE, cnt 0, wr_ready 1, scrub_busy 0, scrub_done 0. rd_data reflects the zeroed array.
- clr asserted mid-scrub zeroes the array immediately and forces IDLE. No scrub_done pulse is produced.
- Write latency: data is visible on a read port the cycle after the accepting edge. With bypass enabled it is visible in the same cycle.
- Scrub latency: scrub_req sampled high in IDLE gives scrub_busy for DEPTH cycles, then scrub_done for 1 cycle. wr_ready is low for DEPTH+1 cycles.
- cnt is ADDR_W wide and is never allowed to wrap; the exit condition is cnt==DEPTH-1.

## Configuration

- RF_BYPASS_EN
  - Defined: when wr_en && wr_ready && wr_addr==rd_addr[k], rd_data[k] = wr_data in the same cycle (write-through forwarding). ZERO_R0 masking still wins.
  - Undefined: rd_data[k] returns the stored value, which is the old value until the edge.

## Structure

- Shared package `rf_pkg` holds:
  - scrub state enum (IDLE, SCRUB, DONE)
  - default DATA_W/ADDR_W/NREAD localparams
  - DEPTH function of ADDR_W
- One sub-module, `rf_scrub_fsm`: owns state and cnt, and outputs scrub_busy, scrub_done, wr_ready, scrub_we and scrub_addr. The top level muxes the scrub write onto the array write port.

## Test plan

- clr pulse with the array preloaded -> every port reads 0; wr_ready=1, scrub_busy=0, scrub_done=0.
- Write 0xBEEF to addr 5; next cycle rd_addr port0=5, port1=5 -> both read 0xBEEF. Write 0x1234 to addr 0 with ZERO_R0=1 -> addr 0 reads 0x0000.
- With RF_BYPASS_EN: in the same cycle write 0xA5A5 to addr 3 and read addr 3 -> 0xA5A5. Without the macro -> old value.
- Fill all 16 entries with 0xFFFF, pulse scrub_req -> scrub_busy high for 16 cycles, scrub_done pulse in cycle 17. After k SCRUB cycles, entries 0..k-1 read 0 and the rest read 0xFFFF. All entries read 0 afterwards.
- wr_en to addr 7 with 0x5555 during SCRUB -> wr_ready=0 and addr 7 remains 0 after the scrub completes.
- Assert clr at scrub cycle 8 -> immediate IDLE, all entries 0, wr_ready=1, no scrub_done pulse.
